// File: rtl/data_memory_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_memory_responder_if                                                 |
// | Load/store request bus between the core data path and the data memory.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface data_memory_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Error;
  logic        Busy;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, Ready, Error, Busy
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, Ready, Error, Busy
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_memory_responder                                                    |
// | Word-addressed data memory with request/Ready handshake and wait states. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  data_memory_responder_if.slave   bus
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    is_rd_q, is_rd_d;
  logic                    is_wr_q, is_wr_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    busy_q, busy_d;
  logic                    req_err;

  logic [31:0]             mem [0:DEPTH-1];

  // Misaligned, beyond the array, or an ambiguous read+write request
  assign req_err = (bus.Address[1:0] != 2'b00)
                || ((bus.Address >> (ADDR_WIDTH + 2)) != 32'd0)
                || (bus.MemRead && bus.MemWrite);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          is_rd_d = bus.MemRead;
          is_wr_d = bus.MemWrite;
          err_d   = req_err;
          idx_d   = bus.Address[ADDR_WIDTH+1:2];
          wdata_d = bus.WriteData;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Response outputs are registered on the edge that enters RESP
    if (state_d == ST_RESP) begin
      ready_d = 1'b1;
      error_d = err_d;
      if (is_rd_d && !err_d) begin
        rdata_d = mem[idx_d];
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      is_rd_q <= 1'b0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  // Store commits at the edge ending RESP; a coincident reset drops it
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_RESP && is_wr_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.Ready    = ready_q;
  assign bus.Error    = error_q;
  assign bus.Busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_memory_responder                                                 |
// | Scoreboard bench: one DUT with two wait states, one with none.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_data_memory_responder;

  localparam int WA = 2;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model [0:1023];
  logic [31:0] last_a;

  data_memory_responder_if ifa ();
  data_memory_responder_if ifb ();

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WA)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_err(input logic rd, input logic wr, input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0) || (rd && wr);
  endfunction

  always @(negedge clk) begin
    exp_t ea;
    chk("busyA", 32'(ifa.Busy), 32'(qa.size() != 0));
    if (qa.size() == 0) begin
      chk("readyA_idle", 32'(ifa.Ready), 32'd0);
    end else if (ifa.Ready) begin
      ea = qa.pop_front();
      chk("latencyA", 32'(cyc), 32'(ea.due));
      chk("errorA", 32'(ifa.Error), 32'(ea.err));
      chk("rdataA", ifa.ReadData, ea.rdata);
    end
  end

  always @(negedge clk) begin
    exp_t eb;
    chk("busyB", 32'(ifb.Busy), 32'(ifb.Ready));
    if (qb.size() == 0) begin
      chk("readyB_idle", 32'(ifb.Ready), 32'd0);
    end else if (ifb.Ready) begin
      eb = qb.pop_front();
      chk("latencyB", 32'(cyc), 32'(eb.due));
      chk("errorB", 32'(ifb.Error), 32'(eb.err));
      chk("rdataB", ifb.ReadData, eb.rdata);
    end
  end

  task automatic drain_a();
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (qa.size() != 0 && k < 40);
    chk("drainA", 32'(qa.size()), 32'd0);
  endtask

  task automatic drain_b();
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (qb.size() != 0 && k < 40);
    chk("drainB", 32'(qb.size()), 32'd0);
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit alt);
    exp_t e;
    logic er;
    @(negedge clk);
    ifa.MemRead   = rd;
    ifa.MemWrite  = wr;
    ifa.Address   = addr;
    ifa.WriteData = wd;
    @(posedge clk); #1;
    er = exp_err(rd, wr, addr);
    if (rd && !er) last_a = model[addr[11:2]];
    if (wr && !er) model[addr[11:2]] = wd;
    e.due   = cyc + WA;
    e.err   = er;
    e.rdata = last_a;
    qa.push_back(e);
    ifa.MemRead  = 1'b0;
    ifa.MemWrite = 1'b0;
    if (alt) begin
      ifa.Address   = 32'h0000_0024;
      ifa.WriteData = 32'h2222_2222;
    end
    drain_a();
  endtask

  initial begin
    exp_t e;
    int   n0;
    n_checks = 0;
    n_fail   = 0;
    last_a   = 32'd0;
    for (int i = 0; i < 1024; i++) model[i] = 32'd0;
    reset = 1'b1;
    ifa.MemRead = 1'b0; ifa.MemWrite = 1'b0; ifa.Address = 32'd0; ifa.WriteData = 32'd0;
    ifb.MemRead = 1'b0; ifb.MemWrite = 1'b0; ifb.Address = 32'd0; ifb.WriteData = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdataA", ifa.ReadData, 32'd0);
    chk("rst_errorA", 32'(ifa.Error), 32'd0);
    chk("rst_rdataB", ifb.ReadData, 32'd0);
    chk("rst_errorB", 32'(ifb.Error), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Write then read at the earliest legal cycle
    do_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    // Misaligned read leaves ReadData alone
    do_req(1'b1, 1'b0, 32'h0000_0012, 32'd0, 1'b0);
    // Out-of-range write and read+write both leave word 0 intact
    do_req(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 1'b0);
    do_req(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
    do_req(1'b1, 1'b1, 32'h0000_0000, 32'h7777_7777, 1'b0);
    do_req(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
    // Inputs changed after acceptance must not leak into the transaction
    do_req(1'b0, 1'b1, 32'h0000_0024, 32'h3333_3333, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b1);
    do_req(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
    do_req(1'b1, 1'b0, 32'h0000_0024, 32'd0, 1'b0);

    // Reset landing on the RESP cycle of a write
    do_req(1'b0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 1'b0);
    @(negedge clk);
    ifa.MemWrite = 1'b1; ifa.Address = 32'h0000_0040; ifa.WriteData = 32'hCAFE_F00D;
    @(posedge clk); #1;
    e.due = cyc + WA; e.err = 1'b0; e.rdata = last_a;
    qa.push_back(e);
    ifa.MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    last_a = 32'd0;
    @(negedge clk);
    chk("abort_rdataA", ifa.ReadData, 32'd0);
    chk("abort_queueA", 32'(qa.size()), 32'd0);
    repeat (4) @(negedge clk);
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b0);

    // Zero wait states: write, then a continuously held read
    @(negedge clk);
    ifb.MemWrite = 1'b1; ifb.Address = 32'h0000_0080; ifb.WriteData = 32'hA5A5_0F0F;
    e.due = cyc + 1; e.err = 1'b0; e.rdata = 32'd0;
    qb.push_back(e);
    @(posedge clk); #1;
    ifb.MemWrite = 1'b0;
    drain_b();
    @(negedge clk);
    ifb.MemRead = 1'b1;
    n0 = cyc;
    for (int i = 0; i < 5; i++) begin
      e.due = n0 + 1 + 2 * i; e.err = 1'b0; e.rdata = 32'hA5A5_0F0F;
      qb.push_back(e);
    end
    repeat (9) @(negedge clk);
    ifb.MemRead = 1'b0;
    drain_b();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
